// File: rtl/dac_stream.sv
// Mono sample FIFO feeding an I2S DAC serialiser slaved to codec BCLK/DACLRCK; MSB leaves one BCLK after each LRCK edge.
// Latency: 3 clk from a codec edge to action; backpressure: ready low while the FIFO holds DEPTH words, sample held by source.
module dac_stream #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bclk,
    input  logic                       daclrck,
    input  logic [N-1:0]               sample_data,
    input  logic                       valid,
    output logic                       ready,
    output logic                       dacdat,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       underrun
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] N_CNT = BW'(N);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t          state;
    logic [2:0]      bclk_sr;
    logic [2:0]      lrck_sr;
    logic            bclk_fall;
    logic            lrck_fall;
    logic            lrck_rise;
    logic [N-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_nxt;
    logic            push;
    logic            pop;
    logic [N-1:0]    head;
    logic [N-1:0]    frame_q;
    logic [N-1:0]    shift_q;
    logic [BW-1:0]   bit_cnt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // [0],[1] synchronise, [2] holds the previous synchronised value
    assign bclk_fall = bclk_sr[2] & ~bclk_sr[1];
    assign lrck_fall = lrck_sr[2] & ~lrck_sr[1];
    assign lrck_rise = ~lrck_sr[2] & lrck_sr[1];

    assign ready = (fifo_level < LW'(DEPTH));
    assign push  = valid && ready;
    assign pop   = lrck_fall && (fifo_level != '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sr    <= '0;
            lrck_sr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            bclk_sr    <= {bclk_sr[1:0], bclk};
            lrck_sr    <= {lrck_sr[1:0], daclrck};
            fifo_level <= level_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // An LRCK edge wins over a coincident bclk_fall, giving the one-BCLK MSB delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dacdat   <= 1'b0;
            frame_q  <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            underrun <= 1'b0;
        end else if (lrck_fall) begin
            if (pop) begin
                frame_q <= head;
                shift_q <= head;
            end else begin
                frame_q  <= '0;
                shift_q  <= '0;
                underrun <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= LEFT;
        end else if (lrck_rise && state == LEFT) begin
            shift_q <= frame_q;
            bit_cnt <= '0;
            state   <= RIGHT;
        end else if (bclk_fall && state != IDLE) begin
            if (bit_cnt < N_CNT) begin
                dacdat  <= shift_q[N-1];
                shift_q <= {shift_q[N-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end else begin
                dacdat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_stream.sv
// Directed bench for dac_stream: the bench acts as the codec (BCLK master, 64 BCLK per LRCK frame)
// and captures DACDAT on BCLK rising edges.
module tb_dac_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk;
    logic        daclrck;
    logic [15:0] sample_data;
    logic        valid;
    logic        ready;
    logic        dacdat;
    logic [2:0]  fifo_level;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    dac_stream #(.N(16), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bclk        (bclk),
        .daclrck     (daclrck),
        .sample_data (sample_data),
        .valid       (valid),
        .ready       (ready),
        .dacdat      (dacdat),
        .fifo_level  (fifo_level),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Put codec edges 2 ns after a clk negedge so they never coincide with a clk posedge
    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] w);
        @(negedge clk);
        sample_data = w;
        valid       = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic codec_idle(input int n, input logic lr, output int nz);
        nz = 0;
        for (int b = 0; b < n; b++) begin
            bclk    = 1'b0;
            daclrck = lr;
            #80;
            bclk = 1'b1;
            if (dacdat !== 1'b0) nz++;
            #80;
        end
    endtask

    // Rising edge #2..#17 after each LRCK edge carry the 16 bits; all others must be 0
    task automatic codec_frame(output logic [15:0] lw, output logic [15:0] rw, output int stray);
        logic [15:0] w0;
        logic [15:0] w1;
        w0 = '0;
        w1 = '0;
        stray = 0;
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < 32; b++) begin
                bclk = 1'b0;
                if (b == 0) daclrck = (s == 1);
                #80;
                bclk = 1'b1;
                if (b >= 1 && b <= 16) begin
                    if (s == 0) w0[16-b] = dacdat;
                    else        w1[16-b] = dacdat;
                end else if (dacdat !== 1'b0) begin
                    stray++;
                end
                #80;
            end
        end
        lw = w0;
        rw = w1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] lw;
        logic [15:0] rw;
        logic [15:0] words [5];
        int          nz;
        int          stray;
        bit          accepted;

        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3C3C;
        words[3] = 16'h8421; words[4] = 16'hFEDC;

        reset = 1'b0; bclk = 1'b0; daclrck = 1'b1; valid = 1'b0; sample_data = '0;
        #12;
        check_eq("rst_dacdat", dacdat, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_ready", ready, 1);
        #20 reset = 1'b1;

        // Released mid right slot: nothing plays until the first LRCK fall
        push(16'hA5C3);
        check_eq("a_level_pushed", fifo_level, 1);
        align();
        codec_idle(32, 1'b1, nz);
        check_eq("a_idle_quiet", nz, 0);
        codec_frame(lw, rw, stray);
        check_eq("a_left", lw, 16'hA5C3);
        check_eq("a_right", rw, 16'hA5C3);
        check_eq("a_stray", stray, 0);
        check_eq("a_level_after", fifo_level, 0);
        check_eq("a_underrun", underrun, 0);

        // Fill with valid held high; 5th word waits for the first pop
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid       = 1'b1;
            sample_data = words[i];
        end
        check_eq("b_ready_full", ready, 0);
        check_eq("b_level_full", fifo_level, 4);
        repeat (3) @(negedge clk);
        check_eq("b_level_hold", fifo_level, 4);
        align();
        accepted = 1'b0;
        fork
            codec_frame(lw, rw, stray);
            begin
                for (int c = 0; c < 2000 && !accepted; c++) begin
                    @(negedge clk);
                    if (ready) begin
                        @(posedge clk);
                        #1 valid = 1'b0;
                        accepted = 1'b1;
                    end
                end
            end
        join
        check_eq("b_accepted", accepted, 1);
        check_eq("b_level_refill", fifo_level, 4);
        check_eq("b_left0", lw, words[0]);
        check_eq("b_right0", rw, words[0]);
        for (int i = 1; i < 5; i++) begin
            codec_frame(lw, rw, stray);
            check_eq($sformatf("b_left%0d", i), lw, words[i]);
            check_eq($sformatf("b_right%0d", i), rw, words[i]);
            check_eq($sformatf("b_stray%0d", i), stray, 0);
        end
        check_eq("b_level_empty", fifo_level, 0);
        check_eq("b_underrun", underrun, 0);

        // Push lands in the exact clk cycle the LRCK fall pops
        push(16'h1234);
        align();
        fork
            codec_frame(lw, rw, stray);
            begin
                #18;
                sample_data = 16'h4321;
                valid       = 1'b1;
                #10;
                valid = 1'b0;
                check_eq("c_level_same_cycle", fifo_level, 1);
            end
        join
        check_eq("c_left_old", lw, 16'h1234);
        check_eq("c_right_old", rw, 16'h1234);
        codec_frame(lw, rw, stray);
        check_eq("c_left_new", lw, 16'h4321);
        check_eq("c_right_new", rw, 16'h4321);
        check_eq("c_level", fifo_level, 0);
        check_eq("c_underrun", underrun, 0);

        // Empty FIFO: silence and sticky underrun
        codec_frame(lw, rw, stray);
        check_eq("d_left", lw, 0);
        check_eq("d_right", rw, 0);
        check_eq("d_stray", stray, 0);
        check_eq("d_underrun", underrun, 1);
        codec_frame(lw, rw, stray);
        check_eq("d_left2", lw, 0);
        check_eq("d_underrun_sticky", underrun, 1);

        // Reset five bits into a left slot
        push(16'h8001);
        push(16'h0007);
        align();
        fork
            codec_frame(lw, rw, stray);
            begin
                #900;
                check_eq("e_level_pre", fifo_level, 1);
                check_eq("e_underrun_pre", underrun, 1);
                reset = 1'b0;
                #1;
                check_eq("e_rst_dacdat", dacdat, 0);
                check_eq("e_rst_level", fifo_level, 0);
                check_eq("e_rst_underrun", underrun, 0);
                check_eq("e_rst_ready", ready, 1);
                #49 reset = 1'b1;
            end
        join
        push(16'h7FFF);
        align();
        codec_frame(lw, rw, stray);
        check_eq("e_left", lw, 16'h7FFF);
        check_eq("e_right", rw, 16'h7FFF);
        check_eq("e_stray", stray, 0);
        check_eq("e_level", fifo_level, 0);
        check_eq("e_underrun", underrun, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
